uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. Sits directly downstream of the baud-rate tick generator and consumes its single-cycle oversampling `tick`.
- Synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each data bit mid-bit (LSB first). It then checks the stop bit.
- Presents the received byte through a valid/ack holding register with framing-error and overrun flags.

Parameters:
DBITS, 8, data bits per frame (5..9)
OS, 16, tick pulses per bit period (oversampling factor, even, >=4)
SB_TICK, 16, ticks counted in stop state (16 = one stop bit, 32 = two)

Ports:
clk_100MHz  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk_100MHz)
tick  input  1  one-cycle oversampling strobe from baud-rate generator, OS pulses per bit
rx  input  1  asynchronous serial input, idle high
rx_data  output  DBITS  last accepted byte, stable while rx_valid=1
rx_valid  output  1  holding register full; held until rx_ack
rx_ack  input  1  consumer accepts rx_data this cycle (ignored when rx_valid=0)
busy  output  1  1 whenever FSM not in IDLE
framing_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: frame completed while holding register still full and not being acked

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE; tick counter and bit counter go to 0; shift register goes to 0.
  - Both synchroniser flops go to 1.
  - Outputs: rx_data=0, rx_valid=0, busy=0, framing_err=0, overrun_err=0.
  - Reset mid-frame abandons the frame; no flag is raised.
- Synchroniser: two-flop chain on rx produces rx_s. All FSM decisions use rx_s only.
- Counter widths:
  - Tick counter s_cnt is $clog2(max(OS,SB_TICK)) bits.
  - Bit counter n_cnt is $clog2(DBITS) bits.
  - Neither counter ever exceeds its terminal value, so no wrap-around is needed.
- In all non-IDLE states, cycles with tick=0 leave FSM and counters unchanged.
- FSM transitions:
  - IDLE: rx_s=0 (evaluated every clock, independent of tick) -> START, s_cnt=0.
  - START, on tick:
    - If s_cnt==OS/2-1 and rx_s=0: go to DATA, s_cnt=0, n_cnt=0.
    - If s_cnt==OS/2-1 and rx_s=1: glitch, return to IDLE silently.
    - Otherwise: s_cnt+1.
  - DATA, on tick:
    - If s_cnt==OS-1: s_cnt=0 and shift = {rx_s, shift[DBITS-1:1]}. If n_cnt==DBITS-1 go to STOP, else n_cnt+1.
    - Otherwise: s_cnt+1.
  - STOP, on tick:
    - If s_cnt==SB_TICK-1: sample rx_s and go to IDLE.
    - Otherwise: s_cnt+1.
- Frame completion, at the STOP sampling tick:
  - rx_s=1: good frame.
  - rx_s=0: framing_err pulses 1 on the next cycle. The byte is discarded and the holding register is untouched.
- Good-frame handling, registered one cycle after the sampling tick:
  - rx_valid=0: rx_data<=shift, rx_valid<=1.
  - rx_valid=1 and rx_ack=1 in the same cycle: rx_data<=shift, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ack=0: new byte dropped, rx_data keeps the old byte, overrun_err pulses 1.
- Ack handling: rx_ack=1 with rx_valid=1 and no completion that cycle -> rx_valid<=0 next cycle. rx_data keeps its value.
- Back-to-back frames: the FSM is in IDLE at mid-stop-bit and detects the next start edge immediately.
- Latency: rx_valid rises 1 clk after the stop-sampling tick, i.e. about 9.5 bit periods after the start-bit falling edge (DBITS=8).

Test Plan:
- Timing for all scenarios: tick every 52 clk, OS=16, so 1 bit = 832 clk.
  1. Send 0xA5 (8N1) with rx_ack tied low -> rx_valid=1 about 9.5 bit periods after the start edge, rx_data=0xA5, framing_err and overrun_err never pulse, busy falls at mid-stop-bit.
  2. Drive rx low for 3 ticks then high -> FSM returns to IDLE at the 8th tick, rx_valid stays 0, no error pulses.
  3. Send 0x3C with the stop bit forced low -> framing_err is one 1-cycle pulse, rx_valid stays 0, rx_data unchanged (0).
  4. Send 0x11 then 0x22 back-to-back, no ack -> rx_data=0x11, rx_valid=1, one overrun_err pulse at the end of frame 2. Then pulse rx_ack -> rx_valid=0.
  5. Send 0x11, then drive rx_ack=1 exactly in the completion cycle of the following frame 0x22 -> rx_data=0x22, rx_valid stays 1, no overrun_err.
  6. Assert reset=0 for 1 clk during DATA of frame 0x5A, then send 0xC3 -> no output from the aborted frame, rx_data=0xC3 received cleanly.

Source files
------------

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: consumer-side bundle of the UART receive stage.
//   rx_data      received byte, stable while rx_valid=1
//   rx_valid     holding register full; held until rx_ack
//   rx_ack       consumer accepts rx_data this cycle
//   busy         receiver is inside a frame
//   framing_err  one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: byte dropped because the holding register was full
// master = receiver side, slave = consumer side.
interface uart_receiver_if #(
  parameter int DBITS = 8
) ();
  logic [DBITS-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ack;
  logic             busy;
  logic             framing_err;
  logic             overrun_err;

  modport master (
    output rx_data, rx_valid, busy, framing_err, overrun_err,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, busy, framing_err, overrun_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled serial-to-parallel UART receive stage.
// Synchronises rx, validates the start bit at mid-bit, samples DBITS data bits
// LSB first at mid-bit, checks the stop bit and hands the byte to a
// valid/ack holding register.
// Ports:
//   clk_100MHz  system clock, rising edge
//   reset       synchronous, active-low
//   tick        one-cycle oversampling strobe, OS pulses per bit period
//   rx          asynchronous serial input, idle high
//   rx_if       master side of uart_receiver_if (data/valid/ack/busy/error flags)
module uart_receiver #(
  parameter int DBITS   = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  input  logic            tick,
  input  logic            rx,
  uart_receiver_if.master rx_if
);

  localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [S_W-1:0]   s_cnt;
  logic [N_W-1:0]   n_cnt;
  logic [DBITS-1:0] shift;

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_s;

  logic [DBITS-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             busy_q;
  logic             framing_err_q;
  logic             overrun_err_q;

  // Stage p0/p1: two-flop synchroniser; reset to the idle (high) line level
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Frame FSM, counters, shift register and holding register
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state         <= IDLE;
      s_cnt         <= '0;
      n_cnt         <= '0;
      shift         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;

      // A plain ack empties the register; a good frame completing in the
      // same cycle overrides this below and reloads it instead.
      if (rx_valid_q && rx_if.rx_ack) begin
        rx_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            s_cnt  <= '0;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                // line went back high before mid start bit: treat as a glitch
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s_cnt == S_BIT) begin
              s_cnt <= '0;
              shift <= {rx_s, shift[DBITS-1:1]};
              if (n_cnt == N_LAST) begin
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s_cnt == S_STOP) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed
              state  <= IDLE;
              busy_q <= 1'b0;
              if (rx_s) begin
                if (!rx_valid_q || rx_if.rx_ack) begin
                  rx_data_q  <= shift;
                  rx_valid_q <= 1'b1;
                end else begin
                  overrun_err_q <= 1'b1;
                end
              end else begin
                framing_err_q <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data     = rx_data_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.busy        = busy_q;
  assign rx_if.framing_err = framing_err_q;
  assign rx_if.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scenarios plus randomized frames for uart_receiver,
// checked every cycle against a frame-level reference model.
module tb_uart_receiver;
  localparam int DBITS   = 8;
  localparam int OS      = 16;
  localparam int SB_TICK = 16;
  // ticks from start detection to the stop-bit sampling tick
  localparam int FINAL   = OS / 2 + OS * DBITS + SB_TICK;

  logic clk_100MHz = 1'b0;
  logic reset;
  logic tick;
  logic rx;

  uart_receiver_if #(.DBITS(DBITS)) rx_if ();

  uart_receiver #(
    .DBITS  (DBITS),
    .OS     (OS),
    .SB_TICK(SB_TICK)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .tick      (tick),
    .rx        (rx),
    .rx_if     (rx_if)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     tper  = 52;
  int     tcnt  = 0;
  bit     ack_req  = 1'b0;
  bit     ack_arm  = 1'b0;
  bit     ack_fire = 1'b0;
  bit     rand_ack = 1'b0;
  bit     chk_on   = 1'b0;
  int     fe_cnt   = 0;
  int     oe_cnt   = 0;
  logic   vprev    = 1'b0;
  longint last_rise = 0;

  // ---------------- reference model ----------------
  // Frame-level view: count ticks since the start edge was seen on the
  // synchronised line and sample at the mid-bit tick positions.
  bit               mdl_active = 1'b0;
  int               mdl_m      = 0;
  logic [DBITS-1:0] mdl_bits   = '0;
  logic             h1 = 1'b1, h2 = 1'b1;
  logic [DBITS-1:0] exp_data  = '0;
  logic             exp_valid = 1'b0;
  logic             exp_busy  = 1'b0;
  logic             exp_fe    = 1'b0;
  logic             exp_oe    = 1'b0;
  logic             rs;
  bit               good, badf;

  always @(posedge clk_100MHz) begin
    cyc++;
    rs = h2;   // line value as seen after two register delays
    h2 = h1;
    h1 = rx;
    good = 1'b0;
    badf = 1'b0;
    if (!reset) begin
      mdl_active = 1'b0;
      mdl_m      = 0;
      h1 = 1'b1;
      h2 = 1'b1;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      exp_fe    = 1'b0;
      exp_oe    = 1'b0;
    end else begin
      if (!mdl_active) begin
        if (rs == 1'b0) begin
          mdl_active = 1'b1;
          mdl_m      = 0;
        end
      end else if (tick) begin
        mdl_m++;
        if (mdl_m == OS / 2) begin
          if (rs) mdl_active = 1'b0;
        end else if (mdl_m <= OS / 2 + OS * DBITS) begin
          if ((mdl_m - OS / 2) % OS == 0) mdl_bits[(mdl_m - OS / 2) / OS - 1] = rs;
        end else if (mdl_m == FINAL) begin
          mdl_active = 1'b0;
          if (rs) good = 1'b1;
          else    badf = 1'b1;
        end
      end
      exp_oe = 1'b0;
      if (good) begin
        if (!exp_valid || rx_if.rx_ack) begin
          exp_data  = mdl_bits;
          exp_valid = 1'b1;
        end else begin
          exp_oe = 1'b1;
        end
      end else if (exp_valid && rx_if.rx_ack) begin
        exp_valid = 1'b0;
      end
      exp_fe   = badf;
      exp_busy = mdl_active;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare + pulse monitor ----------------
  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (chk_on) begin
        cmp("rx_data",     rx_if.rx_data,     exp_data);
        cmp("rx_valid",    rx_if.rx_valid,    exp_valid);
        cmp("busy",        rx_if.busy,        exp_busy);
        cmp("framing_err", rx_if.framing_err, exp_fe);
        cmp("overrun_err", rx_if.overrun_err, exp_oe);
        if (rx_if.framing_err === 1'b1) fe_cnt++;
        if (rx_if.overrun_err === 1'b1) oe_cnt++;
        if (rx_if.rx_valid === 1'b1 && vprev == 1'b0) last_rise = cyc;
        vprev = rx_if.rx_valid;
      end
    end
  end

  // ---------------- tick generator and rx_ack driver ----------------
  initial begin
    tick = 1'b0;
    rx_if.rx_ack = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      if (ack_fire) begin
        rx_if.rx_ack = 1'b0;
        ack_fire = 1'b0;
      end
      tcnt = (tcnt >= tper - 1) ? 0 : tcnt + 1;
      tick = (tcnt == 0);
      if (ack_arm && tick && mdl_active && mdl_m == FINAL - 1) begin
        // ack lands exactly in the stop-sampling (completion) cycle
        rx_if.rx_ack = 1'b1;
        ack_fire = 1'b1;
        ack_arm  = 1'b0;
      end else if (ack_req) begin
        rx_if.rx_ack = 1'b1;
        ack_fire = 1'b1;
        ack_req  = 1'b0;
      end else if (rand_ack && $urandom_range(0, 149) == 0) begin
        rx_if.rx_ack = 1'b1;
        ack_fire = 1'b1;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    int bc;
    bc = OS * tper;
    rx = 1'b0;
    idle(bc);
    for (int i = 0; i < DBITS; i++) begin
      rx = b[i];
      idle(bc);
    end
    if (stop_ok) begin
      rx = 1'b1;
      idle(bc);
    end else begin
      // low across the sampling point, released well before the next mid-bit
      rx = 1'b0;
      idle(bc * 5 / 8);
      rx = 1'b1;
      idle(bc - bc * 5 / 8);
    end
    rx = 1'b1;
    idle(gap_bits * bc);
  endtask

  task automatic pulse_ack();
    ack_req = 1'b1;
    idle(3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint t0;
    int     bc;
    int     r;
    reset = 1'b0;
    rx    = 1'b1;
    idle(3);
    cmp("reset_rx_valid", rx_if.rx_valid, 0);
    cmp("reset_rx_data",  rx_if.rx_data,  0);
    cmp("reset_busy",     rx_if.busy,     0);
    cmp("reset_errs",     {rx_if.framing_err, rx_if.overrun_err}, 0);
    reset  = 1'b1;
    chk_on = 1'b1;
    idle(5);
    bc = OS * tper;

    // 1: 0xA5, no ack, latency about 9.5 bit periods
    fe_cnt = 0; oe_cnt = 0;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 0);
    idle(bc);
    cmp("s1_data",       rx_if.rx_data,  8'hA5);
    cmp("s1_model_data", exp_data,       8'hA5);
    cmp("s1_valid",      rx_if.rx_valid, 1);
    cmp("s1_latency_ok", ((last_rise - t0) >= 7800 && (last_rise - t0) <= 7960), 1);
    cmp("s1_no_errs",    fe_cnt + oe_cnt, 0);

    // 2: start glitch of 3 ticks
    pulse_ack();
    fe_cnt = 0; oe_cnt = 0;
    rx = 1'b0;
    idle(3 * tper);
    rx = 1'b1;
    idle(12 * tper);
    cmp("s2_busy",    rx_if.busy,     0);
    cmp("s2_valid",   rx_if.rx_valid, 0);
    cmp("s2_no_errs", fe_cnt + oe_cnt, 0);

    // 3: 0x3C with stop bit low
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    fe_cnt = 0; oe_cnt = 0;
    send_frame(8'h3C, 1'b0, 1);
    cmp("s3_fe_pulses",  fe_cnt,         1);
    cmp("s3_valid",      rx_if.rx_valid, 0);
    cmp("s3_data",       rx_if.rx_data,  0);
    cmp("s3_model_data", exp_data,       0);

    // 4: 0x11 then 0x22 back-to-back, no ack -> overrun
    fe_cnt = 0; oe_cnt = 0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1);
    cmp("s4_data",       rx_if.rx_data,  8'h11);
    cmp("s4_model_data", exp_data,       8'h11);
    cmp("s4_valid",      rx_if.rx_valid, 1);
    cmp("s4_oe_pulses",  oe_cnt,         1);
    pulse_ack();
    cmp("s4_valid_after_ack", rx_if.rx_valid, 0);

    // 5: ack coinciding with completion of the second frame
    fe_cnt = 0; oe_cnt = 0;
    send_frame(8'h11, 1'b1, 0);
    ack_arm = 1'b1;
    send_frame(8'h22, 1'b1, 1);
    cmp("s5_ack_hit",    ack_arm,        0);
    cmp("s5_data",       rx_if.rx_data,  8'h22);
    cmp("s5_model_data", exp_data,       8'h22);
    cmp("s5_valid",      rx_if.rx_valid, 1);
    cmp("s5_oe_pulses",  oe_cnt,         0);

    // 6: reset during DATA of 0x5A (frame abandoned), then 0xC3
    pulse_ack();
    fe_cnt = 0; oe_cnt = 0;
    rx = 1'b0;          // start bit
    idle(bc);
    rx = 1'b0;          // data bit 0
    idle(bc);
    rx = 1'b1;          // data bit 1
    idle(bc / 2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(bc / 2 + 2 * bc);
    cmp("s6_busy_after_abort",  rx_if.busy,     0);
    cmp("s6_valid_after_abort", rx_if.rx_valid, 0);
    send_frame(8'hC3, 1'b1, 1);
    cmp("s6_data",       rx_if.rx_data,  8'hC3);
    cmp("s6_model_data", exp_data,       8'hC3);
    cmp("s6_valid",      rx_if.rx_valid, 1);
    cmp("s6_no_errs",    fe_cnt + oe_cnt, 0);

    // random frames, glitches and acks on a faster tick
    tper = 2;
    pulse_ack();
    rand_ack = 1'b1;
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rx = 1'b0;
        idle($urandom_range(1, 5) * tper);
        rx = 1'b1;
        idle(2 * OS * tper);
      end else begin
        send_frame(8'($urandom_range(0, 255)), (r != 1), $urandom_range(0, 2));
      end
    end
    rand_ack = 1'b0;
    idle(2 * OS * tper);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
